// File: rtl/uart_fifo_pkg.sv
// rtl/uart_fifo_pkg.sv - shared constants for the UART receive/transmit FIFO
package uart_fifo_pkg;
    localparam int UART_FIFO_WIDTH      = 8;
    localparam int UART_FIFO_ADDR_WIDTH = 4;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;
endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - FIFO storage: one synchronous write port, one asynchronous read port
module uart_fifo_mem
    import uart_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = UART_FIFO_WIDTH,
    parameter int ADDR_WIDTH = UART_FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [FIFO_WIDTH-1:0] w_data,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [FIFO_WIDTH-1:0] r_data
);
    logic [FIFO_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    // No reset: stored words are simply abandoned when the pointers clear.
    always_ff @(posedge clk) begin
        if (w_en) begin
            mem_q[w_addr] <= w_data;
        end
    end

    assign r_data = mem_q[r_addr];
endmodule

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock UART FIFO with std/FWFT read, thresholds and sticky errors
module uart_sync_fifo
    import uart_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = UART_FIFO_WIDTH,
    parameter int ADDR_WIDTH = UART_FIFO_ADDR_WIDTH,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  w_en,
    input  logic [FIFO_WIDTH-1:0] w_data,
    input  logic                  r_en,
    output logic [FIFO_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic [ADDR_WIDTH:0]   avail_data,
    output logic [ADDR_WIDTH:0]   avail_room,
    output logic                  is_empty,
    output logic                  is_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(1 << ADDR_WIDTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [CW-1:0]         wr_pt_q, wr_pt_d, rd_pt_q, rd_pt_d, count_q, count_d;
    logic [CW-1:0]         room_q;
    logic [FIFO_WIDTH-1:0] r_data_q, r_data_d, mem_rdata;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  r_valid_q, r_valid_d;
    logic                  empty_q, full_q, ae_q, af_q;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  wr_acc, rd_acc;

    always_comb begin
        wr_acc  = w_en & ~full_q & ~flush;
        rd_acc  = r_en & ~empty_q & ~flush;
        wr_pt_d = flush ? '0 : wr_pt_q + CW'(wr_acc);
        rd_pt_d = flush ? '0 : rd_pt_q + CW'(rd_acc);
        count_d = flush ? '0 : count_q + CW'(wr_acc) - CW'(rd_acc);
        // Set beats clear; a flush cycle leaves both sticky flags alone.
        ovf_d   = flush ? ovf_q : ((w_en & full_q) | (ovf_q & ~err_clr));
        unf_d   = flush ? unf_q : ((r_en & empty_q) | (unf_q & ~err_clr));

        if (FWFT == FIFO_MODE_FWFT) begin
            rd_addr   = rd_pt_d[ADDR_WIDTH-1:0];
            r_valid_d = (count_d != '0);
            // Write-through when the slot being written is the next one presented.
            if (flush)
                r_data_d = r_data_q;
            else if (wr_acc && (wr_pt_q == rd_pt_d))
                r_data_d = w_data;
            else
                r_data_d = mem_rdata;
        end else begin
            rd_addr   = rd_pt_q[ADDR_WIDTH-1:0];
            r_valid_d = rd_acc;
            r_data_d  = rd_acc ? mem_rdata : r_data_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pt_q   <= '0;
            rd_pt_q   <= '0;
            count_q   <= '0;
            room_q    <= DEPTH_C;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            ae_q      <= 1'b1;
            af_q      <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wr_pt_q   <= wr_pt_d;
            rd_pt_q   <= rd_pt_d;
            count_q   <= count_d;
            room_q    <= DEPTH_C - count_d;
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
            empty_q   <= (count_d == '0);
            full_q    <= (count_d == DEPTH_C);
            ae_q      <= (count_d <= AE_C);
            af_q      <= (count_d >= AF_C);
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    uart_fifo_mem #(
        .FIFO_WIDTH(FIFO_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .w_en  (wr_acc),
        .w_addr(wr_pt_q[ADDR_WIDTH-1:0]),
        .w_data(w_data),
        .r_addr(rd_addr),
        .r_data(mem_rdata)
    );

    assign r_data       = r_data_q;
    assign r_valid      = r_valid_q;
    assign avail_data   = count_q;
    assign avail_room   = room_q;
    assign is_empty     = empty_q;
    assign is_full      = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
endmodule

// File: doc/uart_sync_fifo.md
# uart_sync_fifo

Single-clock, parametrised receive/transmit buffer for the 8051 UART datapath, sitting between the UART shift engines and the SFR bus interface. It generalises the earlier UART FIFO in three ways: width and depth are free parameters, a selectable first-word-fall-through read mode is added, and it provides programmable almost-full/almost-empty thresholds plus sticky overflow/underflow error flags. All status outputs are registered and update on the same edge as the occupancy count.

## Interface
- FIFO_WIDTH, 8, data word width in bits
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH entries
- FWFT, 0, read mode: 0 = registered read with 1-cycle latency, 1 = first-word-fall-through
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (legal range 1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (legal range 0..DEPTH-1)

Ports:
- clk  in  1  clock, all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pointer/count clear
- w_en  in  1  write request
- w_data  in  FIFO_WIDTH  write data
- r_en  in  1  read (pop) request
- r_data  out  FIFO_WIDTH  read data
- r_valid  out  1  FWFT=0: read-data strobe; FWFT=1: equals !is_empty
- avail_data  out  ADDR_WIDTH+1  stored entries, 0..DEPTH
- avail_room  out  ADDR_WIDTH+1  free entries, DEPTH - avail_data
- is_empty / is_full  out  1  count == 0 / count == DEPTH
- almost_empty / almost_full  out  1  threshold flags
- overflow / underflow  out  1  sticky error flags
- err_clr  in  1  clears both sticky flags

## Operation
- Pointers are ADDR_WIDTH+1 bits; storage is indexed by the low ADDR_WIDTH bits. Full means MSBs differ with low bits equal; empty means pointers are equal. Pointers wrap naturally from 2*DEPTH-1 to 0.
- Accepted write: wr_acc = w_en & !is_full. Accepted read: rd_acc = r_en & !is_empty. Both are evaluated against the current registered flags.
- A write while full is dropped and sets overflow. A read while empty is ignored and sets underflow, with r_data unchanged.
- Simultaneous read and write:
  - When neither full nor empty, both are accepted and the count is unchanged.
  - When full, the read is accepted and the write is dropped (overflow is set).
  - When empty, the write is accepted and the read is rejected (underflow is set).
- Count update: count_nxt = count + wr_acc - rd_acc. Every flag is computed from count_nxt and registered.
- flush has top priority. It sets both pointers and the count to 0, so the flags go to their reset values. It suppresses any w_en/r_en in the same cycle and leaves r_data, overflow and underflow unchanged.
- Sticky flags: if set and err_clr occur in the same cycle, set wins.
- FWFT=0:
  - On the rd_acc edge, r_data <= mem[r_pt] and r_valid goes to 1 for exactly one cycle.
  - Otherwise r_valid = 0 and r_data holds.
- FWFT=1:
  - r_data is registered as mem[r_pt_nxt] every cycle.
  - Write-through: if the write targets slot r_pt_nxt while the FIFO is empty or about to become empty, r_data takes w_data directly.
  - r_data is valid whenever is_empty = 0. r_en pops the presented word.

## Timing
- Reset values: r_data = 0, r_valid = 0, avail_data = 0, avail_room = DEPTH, is_empty = 1, is_full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0, pointers = 0.
- Write to read availability is 1 cycle: is_empty deasserts on the edge that accepts the first write.
- FWFT=0 read latency is 1 cycle from the r_en edge to r_data/r_valid.
- FWFT=1: the first word is present on r_data on the same edge that clears is_empty. Back-to-back pops at 1 word/cycle are supported.
- Sustained throughput is 1 write plus 1 read per cycle.
- Reset may assert mid-operation. All state clears immediately and the stored data is discarded (the memory itself is not cleared).

## Structure
- Package uart_fifo_pkg holds:
  - the default FIFO_WIDTH and ADDR_WIDTH constants;
  - the FWFT mode encodings FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1.
- Sub-module uart_fifo_mem: a DEPTH x FIFO_WIDTH register array with one synchronous write port and one asynchronous read port. The top level does all registering of r_data.
- The top level contains the pointers, count, flags and mode mux.

## Test plan
- Defaults, FWFT=0: write 0x11..0x20 (16 words). Expect is_full = 1, avail_room = 0 and almost_full set from count 14. Then 16 reads return 0x11..0x20, r_valid pulses 1 cycle after each r_en, and the FIFO ends with is_empty = 1.
- Full, w_en = 1 with w_data = 0xAA: overflow sets, count stays at 16 and 0xAA never appears. Pulse err_clr and overflow clears. Assert err_clr together with a new overflow and overflow stays 1.
- Empty, r_en = 1: underflow sets and r_data holds its previous value. Simultaneous w_en/r_en on empty: the write is accepted, avail_data = 1 and underflow sets.
- FWFT=1: write 0x5A into an empty FIFO. The next cycle r_data = 0x5A and r_valid = 1. Pop together with a write of 0x5B: r_data = 0x5B and the count stays at 1.
- Wrap-around: 40 interleaved single writes/reads. Data order is preserved across the pointer MSB toggle and avail_data + avail_room = 16 throughout.
- Load 5 words, assert flush together with w_en: avail_data = 0, is_empty = 1 and the write is discarded. Assert rst mid-burst: all outputs return to their reset values asynchronously.
